dma_desc_fetch: RTL and testbench

Descriptor fetch stage sitting directly upstream of the ADMA transfer state machine. On a start pulse it walks the descriptor table in system memory through a request/acknowledge read port. It decodes each 64-bit descriptor into the valid, end, act1, act2 and address fields the DMA core consumes, and presents them with a ready/take handshake. It advances the table pointer by one descriptor, or jumps on a link descriptor, until an end descriptor is consumed or an invalid descriptor is hit.

---
 rtl/dma_pkg.sv | 48 ++++
 rtl/dma_desc_decode.sv | 38 +++
 rtl/dma_desc_fetch.sv | 226 ++++++++++++++++++++++
 tb/tb_dma_desc_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
//==============================================================================
// Module      : dma_pkg
// Description : Shared types and constants for the DMA descriptor fetch stage:
//               FSM state encoding, descriptor attribute bit positions, field
//               ranges, act encodings and the link-target helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dma_pkg;

  localparam int ADDR_W = 64;
  localparam logic [63:0] DESC_BYTES = 64'd8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_ERROR   = 2'd3
  } state_e;

  // Attribute bit positions inside the low byte of a descriptor
  localparam int BIT_VALID = 0;
  localparam int BIT_END   = 1;
  localparam int BIT_INT   = 2;
  localparam int BIT_ACT1  = 4;
  localparam int BIT_ACT2  = 5;

  // Field ranges
  localparam int LEN_LSB  = 16;
  localparam int LEN_MSB  = 31;
  localparam int ADDR_LSB = 32;
  localparam int ADDR_MSB = 63;

  // {act2, act1} encodings
  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_RSV  = 2'b01;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  // Next table pointer for a link descriptor: 8-byte aligned, zero-extended
  function automatic logic [63:0] link_target(input logic [63:0] word);
    return {32'h0, word[63:35], 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dma_desc_decode.sv
//==============================================================================
// Module      : dma_desc_decode
// Description : Purely combinational split of a 64-bit descriptor word into
//               attribute flags, raw length and zero-extended address.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dma_desc_decode
  import dma_pkg::*;
(
  input  logic [63:0] word,
  output logic        valid,
  output logic        end_flag,
  output logic        int_flag,
  output logic        act1,
  output logic        act2,
  output logic        is_link,
  output logic [15:0] len,
  output logic [63:0] addr
);

  // Bits the DMA core does not interpret
  logic unused_bits;

  assign valid       = word[BIT_VALID];
  assign end_flag    = word[BIT_END];
  assign int_flag    = word[BIT_INT];
  assign act1        = word[BIT_ACT1];
  assign act2        = word[BIT_ACT2];
  assign is_link     = ({word[BIT_ACT2], word[BIT_ACT1]} == ACT_LINK);
  assign len         = word[LEN_MSB:LEN_LSB];
  assign addr        = {32'h0, word[ADDR_MSB:ADDR_LSB]};
  assign unused_bits = ^{word[15:6], word[3]};

endmodule

`default_nettype wire

// File: rtl/dma_desc_fetch.sv
//==============================================================================
// Module      : dma_desc_fetch
// Description : Walks an ADMA descriptor table through a req/ack read port and
//               presents decoded descriptors to the DMA core with rdy/take.
//               Optional build macro DESC_PREFETCH_EN adds a one-entry
//               prefetch buffer for a sustained rate of one descriptor/cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dma_desc_fetch
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] desc_base,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              desc_rdy,
  input  logic              desc_take,
  output logic              valid_IN,
  output logic              End_IN,
  output logic              act1_IN,
  output logic              act2_IN,
  output logic              desc_int,
  output logic [15:0]       desc_len,
  output logic [ADDR_W-1:0] addr_COM,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e      state_q, state_d;
  logic [63:0] ptr_q, ptr_d;
  logic [63:0] word_q, word_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [63:0] seq_next;
  logic        cur_end;
  logic        cur_link;
  logic        unused_base;

  assign unused_base = ^desc_base[2:0];
  assign seq_next    = ptr_q + DESC_BYTES;

  // Decode of the descriptor currently held for the core
  dma_desc_decode u_cur_decode (
    .word     (word_q),
    .valid    (valid_IN),
    .end_flag (cur_end),
    .int_flag (desc_int),
    .act1     (act1_IN),
    .act2     (act2_IN),
    .is_link  (cur_link),
    .len      (desc_len),
    .addr     (addr_COM)
  );

  assign End_IN = cur_end;

`ifdef DESC_PREFETCH_EN
  logic [63:0] buf_word_q, buf_word_d;
  logic        buf_full_q, buf_full_d;
  logic [63:0] cand;
  logic        buf_valid, buf_end, buf_link;
  logic        unused_buf_int, unused_buf_act1, unused_buf_act2;
  logic [15:0] unused_buf_len;
  logic [63:0] unused_buf_addr;

  // Decode of the prefetched word, used to decide whether to chain further
  dma_desc_decode u_buf_decode (
    .word     (buf_word_q),
    .valid    (buf_valid),
    .end_flag (buf_end),
    .int_flag (unused_buf_int),
    .act1     (unused_buf_act1),
    .act2     (unused_buf_act2),
    .is_link  (buf_link),
    .len      (unused_buf_len),
    .addr     (unused_buf_addr)
  );
`endif

  // Next-state, pointer update and memory request generation
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    word_d   = word_q;
    err_d    = err_q;
    done_d   = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
`ifdef DESC_PREFETCH_EN
    buf_word_d = buf_word_q;
    buf_full_d = buf_full_q;
    cand       = buf_word_q;
`endif

    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (start) begin
          ptr_d   = {desc_base[63:3], 3'b000};
          err_d   = 1'b0;
          state_d = S_FETCH;
`ifdef DESC_PREFETCH_EN
          buf_full_d = 1'b0;
`endif
        end
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = ptr_q;
        if (mem_ack) begin
          // An invalid word is never shown to the core, so it is not captured
          if (mem_rdata[BIT_VALID]) begin
            word_d  = mem_rdata;
            state_d = S_PRESENT;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end
        end
      end

      S_PRESENT: begin
`ifdef DESC_PREFETCH_EN
        // Chain ahead only along a sequential run; a full buffer may be
        // refilled in the same cycle it drains into the present register.
        if (!cur_end && !cur_link) begin
          if (!buf_full_q) begin
            mem_req  = 1'b1;
            mem_addr = seq_next;
          end else if (desc_take && buf_valid && !buf_end && !buf_link) begin
            mem_req  = 1'b1;
            mem_addr = seq_next + DESC_BYTES;
          end
        end
        if (mem_req && mem_ack && !desc_take) begin
          buf_word_d = mem_rdata;
          buf_full_d = 1'b1;
        end
`endif
        if (desc_take) begin
          if (cur_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (cur_link) begin
            ptr_d   = link_target(word_q);
            state_d = S_FETCH;
          end else begin
            ptr_d   = seq_next;
`ifdef DESC_PREFETCH_EN
            if (buf_full_q || (mem_req && mem_ack)) begin
              cand = buf_full_q ? buf_word_q : mem_rdata;
              if (buf_full_q && mem_req && mem_ack) begin
                buf_word_d = mem_rdata;
                buf_full_d = 1'b1;
              end else begin
                buf_full_d = 1'b0;
              end
              // A bad prefetched word only errors once it reaches the front
              if (cand[BIT_VALID]) begin
                word_d = cand;
              end else begin
                err_d      = 1'b1;
                state_d    = S_ERROR;
                buf_full_d = 1'b0;
              end
            end else begin
              buf_full_d = 1'b0;
              state_d    = S_FETCH;
            end
`else
            state_d = S_FETCH;
`endif
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef DESC_PREFETCH_EN
  // Prefetch buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_word_q <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_word_q <= buf_word_d;
      buf_full_q <= buf_full_d;
    end
  end
`endif

  // ERROR is a parked state awaiting start, so it does not count as busy
  assign desc_rdy = (state_q == S_PRESENT);
  assign busy     = (state_q == S_FETCH) || (state_q == S_PRESENT);
  assign done     = done_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_desc_fetch.sv
//==============================================================================
// Module      : tb_dma_desc_fetch
// Description : Self-checking bench for dma_desc_fetch with a behavioural
//               memory responder and a descriptor scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dma_desc_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] desc_base = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        desc_rdy;
  logic        desc_take = 1'b0;
  logic        valid_IN, End_IN, act1_IN, act2_IN, desc_int;
  logic [15:0] desc_len;
  logic [63:0] addr_COM;
  logic        busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem [logic [63:0]];
  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_desc_q[$];
  int          mem_lat   = 0;
  int          wait_cnt  = 0;
  logic        force_ack = 1'b0;
  int          done_cnt  = 0;
  int          rdy_cnt   = 0;

  always #5 clk = ~clk;

  dma_desc_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .desc_base (desc_base),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .desc_rdy  (desc_rdy),
    .desc_take (desc_take),
    .valid_IN  (valid_IN),
    .End_IN    (End_IN),
    .act1_IN   (act1_IN),
    .act2_IN   (act2_IN),
    .desc_int  (desc_int),
    .desc_len  (desc_len),
    .addr_COM  (addr_COM),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_desc(input logic [63:0] w);
    check("valid_IN", valid_IN, w[0]);
    check("End_IN",   End_IN,   w[1]);
    check("desc_int", desc_int, w[2]);
    check("act1_IN",  act1_IN,  w[4]);
    check("act2_IN",  act2_IN,  w[5]);
    check("desc_len", desc_len, w[31:16]);
    check("addr_COM", addr_COM, {32'h0, w[63:32]});
  endtask

  // Consumer, then (1 ns later, once mem_req has settled) memory responder
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (desc_rdy) begin
      desc_take = 1'b1;
      rdy_cnt++;
      if (exp_desc_q.size() == 0) check("desc_unexpected", desc_rdy, 1'b0);
      else check_desc(exp_desc_q.pop_front());
    end else begin
      desc_take = 1'b0;
    end
    #1;
    if (mem_req) begin
      if (wait_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'h0;
        wait_cnt  = 0;
        if (exp_addr_q.size() == 0) check("fetch_unexpected", mem_req, 1'b0);
        else check("mem_addr", mem_addr, exp_addr_q.pop_front());
      end else begin
        mem_ack  = force_ack;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack   = force_ack;
      mem_rdata = 64'h00000BBB_00100023;
      wait_cnt  = 0;
    end
  end

  task automatic do_start(input logic [63:0] base);
    @(negedge clk);
    start     = 1'b1;
    desc_base = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i >= 200) check(tag, busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic wait_rdy(input string tag);
    int i;
    for (i = 0; i < 50 && !desc_rdy; i++) @(negedge clk);
    if (!desc_rdy) check(tag, desc_rdy, 1'b1);
  endtask

  task automatic push_chain(input logic [63:0] a, input logic [63:0] w);
    mem[a] = w;
    exp_addr_q.push_back(a);
    exp_desc_q.push_back(w);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_addr_left"}, exp_addr_q.size(), 0);
    check({tag, "_desc_left"}, exp_desc_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_req",  mem_req,  1'b0);
    check("rst_desc_rdy", desc_rdy, 1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_err",      err,      1'b0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_addr_COM", addr_COM, 64'h0);
    check("rst_desc_len", desc_len, 16'h0);
    reset = 1'b0;

    // Single end descriptor, ack one cycle after request
    mem_lat = 1;
    done_cnt = 0;
    push_chain(64'h1000, 64'h00000BBB_00100023);
    do_start(64'h1000);
    check("start_to_req", mem_req, 1'b1);
    wait_idle("single_timeout");
    check("single_done_cnt", done_cnt, 1);
    check("single_busy", busy, 1'b0);
    check_drained("single");

    // Three-descriptor tran chain, zero-wait memory
    mem_lat = 0;
    done_cnt = 0;
    push_chain(64'h2000, 64'h0000A000_02000021);
    push_chain(64'h2008, 64'h0000A100_02000021);
    push_chain(64'h2010, 64'h0000A200_02000023);
    do_start(64'h2000);
    wait_rdy("chain_rdy_timeout");
    @(negedge clk);
`ifdef DESC_PREFETCH_EN
    check("chain_rdy_b2b", desc_rdy, 1'b1);
`else
    check("chain_rdy_gap", desc_rdy, 1'b0);
`endif
    @(negedge clk);
    check("chain_rdy_next", desc_rdy, 1'b1);
    wait_idle("chain_timeout");
    check("chain_done_cnt", done_cnt, 1);
    check_drained("chain");

    // Link descriptor jumps to 0x3000
    done_cnt = 0;
    push_chain(64'h2000, 64'h00003000_00000031);
    push_chain(64'h3000, 64'h00000777_00080007);
    do_start(64'h2000);
    wait_idle("link_timeout");
    check("link_done_cnt", done_cnt, 1);
    check_drained("link");

    // Invalid descriptor: error, nothing presented, then restart clears err
    done_cnt = 0;
    rdy_cnt  = 0;
    mem[64'h4000] = 64'h00000123_00100022;
    exp_addr_q.push_back(64'h4000);
    do_start(64'h4000);
    wait_idle("inv_timeout");
    check("inv_err",      err,      1'b1);
    check("inv_busy",     busy,     1'b0);
    check("inv_rdy_cnt",  rdy_cnt,  0);
    check("inv_done_cnt", done_cnt, 0);
    push_chain(64'h1000, 64'h00000BBB_00100023);
    do_start(64'h1000);
    check("restart_err_clr", err, 1'b0);
    check("restart_req", mem_req, 1'b1);
    wait_idle("restart_timeout");
    check("restart_done_cnt", done_cnt, 1);
    check_drained("inv");

    // Unaligned base near the top of memory; sequential step wraps to 0
    done_cnt = 0;
    push_chain(64'hFFFF_FFFF_FFFF_FFF8, 64'h00000010_00200021);
    push_chain(64'h0, 64'h00000020_00300003);
    do_start(64'hFFFF_FFFF_FFFF_FFFD);
    wait_idle("wrap_timeout");
    check("wrap_done_cnt", done_cnt, 1);
    check_drained("wrap");

`ifdef DESC_PREFETCH_EN
    // Four-descriptor chain streams at one per cycle
    done_cnt = 0;
    push_chain(64'h5000, 64'h00001000_00400021);
    push_chain(64'h5008, 64'h00001100_00400021);
    push_chain(64'h5010, 64'h00001200_00400021);
    push_chain(64'h5018, 64'h00001300_00400023);
    do_start(64'h5000);
    wait_rdy("pf_rdy_timeout");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pf_rdy_cont", desc_rdy, 1'b1);
    end
    wait_idle("pf_timeout");
    check("pf_done_cnt", done_cnt, 1);
    check_drained("pf");
`endif

    // Async reset while a fetch is pending; a late ack must be ignored
    mem_lat = 20;
    do_start(64'h1000);
    repeat (3) @(negedge clk);
    check("arst_req_before", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_mem_req",  mem_req,  1'b0);
    check("arst_busy",     busy,     1'b0);
    check("arst_mem_addr", mem_addr, 64'h0);
    check("arst_desc_rdy", desc_rdy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("late_ack_rdy",  desc_rdy, 1'b0);
    check("late_ack_busy", busy,     1'b0);
    check("late_ack_err",  err,      1'b0);
    check_drained("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
